// File: rtl/fpu_seq_if.sv
// Issue and writeback handshake bundle between the integer pipeline and fpu_seq.
interface fpu_seq_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_op;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_rm;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [4:0]  wb_flags;

  modport master (
    output issue_valid, issue_op, issue_rs1, issue_rs2, issue_rd, issue_rm, wb_ready,
    input  issue_ready, wb_valid, wb_data, wb_rd, wb_flags
  );

  modport slave (
    input  issue_valid, issue_op, issue_rs1, issue_rs2, issue_rd, issue_rm, wb_ready,
    output issue_ready, wb_valid, wb_data, wb_rd, wb_flags
  );
endinterface

// File: rtl/fpu_seq.sv
// Single-op sequencer for the shared FP datapath: holds operands for the op's fixed latency,
// then returns the result via writeback. FPU_SEQ_FLAGS_EN enables the sticky fflags_acc register.
module fpu_seq #(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 16,
  parameter int unsigned LAT_SQRT = 16,
  parameter int unsigned LAT_CVT  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  fpu_seq_if.slave    sif,
  input  logic [2:0]  fcsr_frm,
  input  logic        flush,
  output logic [5:0]  fpu_op,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  output logic [2:0]  fpu_rm,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        busy,
  output logic [4:0]  fflags_acc,
  input  logic        fflags_clr
);

  localparam int unsigned LAT_M0  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int unsigned LAT_M1  = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT;
  localparam int unsigned LAT_M2  = (LAT_M0 > LAT_M1) ? LAT_M0 : LAT_M1;
  localparam int unsigned LAT_MAX = (LAT_M2 > LAT_CVT) ? LAT_M2 : LAT_CVT;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        fpu_op_q, fpu_op_d;
  logic [31:0]       fpu_rs1_q, fpu_rs1_d;
  logic [31:0]       fpu_rs2_q, fpu_rs2_d;
  logic [2:0]        fpu_rm_q, fpu_rm_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_flags_q, wb_flags_d;

  logic [2:0]        rm_res;
  logic              illegal;
  logic              accept;
  logic [CNT_W-1:0]  lat_sel;

  always_comb begin
    rm_res  = (sif.issue_rm == 3'd7) ? fcsr_frm : sif.issue_rm;
    illegal = (sif.issue_op[5:3] != 3'd0) | (rm_res >= 3'd5);
    case (sif.issue_op[2:0])
      3'd0:    lat_sel = CNT_W'(LAT_ADD);
      3'd1:    lat_sel = CNT_W'(LAT_MUL);
      3'd2:    lat_sel = CNT_W'(LAT_DIV);
      3'd3:    lat_sel = CNT_W'(LAT_SQRT);
      default: lat_sel = CNT_W'(LAT_CVT);
    endcase

    sif.issue_ready = !flush & ((state_q == IDLE) | ((state_q == DONE) & sif.wb_ready));
    accept          = sif.issue_valid & sif.issue_ready;

    state_d    = state_q;
    cnt_d      = cnt_q;
    fpu_op_d   = fpu_op_q;
    fpu_rs1_d  = fpu_rs1_q;
    fpu_rs2_d  = fpu_rs2_q;
    fpu_rm_d   = fpu_rm_q;
    rd_d       = rd_q;
    wb_data_d  = wb_data_q;
    wb_flags_d = wb_flags_q;

    case (state_q)
      EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          wb_data_d  = fpu_result;
          wb_flags_d = fpu_flags;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: if (sif.wb_ready) state_d = IDLE;
      default: ;
    endcase

    // A new accept overrides the DONE->IDLE move so back-to-back ops have no bubble.
    if (accept) begin
      rd_d = sif.issue_rd;
      if (illegal) begin
        state_d    = DONE;
        wb_data_d  = '0;
        wb_flags_d = 5'b10000;
      end else begin
        state_d   = EXEC;
        fpu_op_d  = sif.issue_op;
        fpu_rs1_d = sif.issue_rs1;
        fpu_rs2_d = sif.issue_rs2;
        fpu_rm_d  = rm_res;
        cnt_d     = lat_sel;
      end
    end

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fpu_op_q   <= '0;
      fpu_rs1_q  <= '0;
      fpu_rs2_q  <= '0;
      fpu_rm_q   <= '0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      wb_flags_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fpu_op_q   <= fpu_op_d;
      fpu_rs1_q  <= fpu_rs1_d;
      fpu_rs2_q  <= fpu_rs2_d;
      fpu_rm_q   <= fpu_rm_d;
      rd_q       <= rd_d;
      wb_data_q  <= wb_data_d;
      wb_flags_q <= wb_flags_d;
    end
  end

  assign fpu_op       = fpu_op_q;
  assign fpu_rs1      = fpu_rs1_q;
  assign fpu_rs2      = fpu_rs2_q;
  assign fpu_rm       = fpu_rm_q;
  assign sif.wb_valid = (state_q == DONE);
  assign sif.wb_data  = wb_data_q;
  assign sif.wb_rd    = rd_q;
  assign sif.wb_flags = wb_flags_q;
  assign busy         = (state_q != IDLE);

`ifdef FPU_SEQ_FLAGS_EN
  logic [4:0] acc_q, acc_d;

  // Clear has priority over a same-cycle writeback; flushed handshakes do not accumulate.
  always_comb begin
    acc_d = acc_q;
    if (sif.wb_valid & sif.wb_ready & !flush) acc_d = acc_q | wb_flags_q;
    if (fflags_clr) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign fflags_acc = acc_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr;
  assign fflags_acc        = '0;
`endif

endmodule

// File: tb/tb_fpu_seq.sv
// Scoreboard bench for fpu_seq: driver pushes expected writebacks, a negedge monitor pops and compares.
module tb_fpu_seq;
  localparam int LA = 3, LM = 3, LD = 16, LS = 16, LC = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        fflags_clr = 1'b0;
  logic [2:0]  fcsr_frm = 3'd0;
  logic [5:0]  fpu_op;
  logic [31:0] fpu_rs1, fpu_rs2, fpu_result;
  logic [2:0]  fpu_rm;
  logic [4:0]  fpu_flags, fflags_acc;
  logic        busy;
  logic        wb_rand = 1'b0;

  fpu_seq_if bus ();

  fpu_seq #(.LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD), .LAT_SQRT(LS), .LAT_CVT(LC)) dut (
    .clk(clk), .resetn(resetn), .sif(bus), .fcsr_frm(fcsr_frm), .flush(flush),
    .fpu_op(fpu_op), .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2), .fpu_rm(fpu_rm),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags), .busy(busy),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: deterministic result from the presented operands, flags from rs1[4:0].
  function automatic logic [31:0] dp_res(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [2:0] rm);
    if (op == 6'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a ^ {b[18:0], b[31:19]}) + ({26'd0, op} * 32'h0100_0193) + {29'd0, rm};
  endfunction

  assign fpu_result = dp_res(fpu_op, fpu_rs1, fpu_rs2, fpu_rm);
  assign fpu_flags  = fpu_rs1[4:0];

  function automatic int lat_of(input logic [5:0] op);
    case (op)
      6'd0: return LA;
      6'd1: return LM;
      6'd2: return LD;
      6'd3: return LS;
      default: return LC;
    endcase
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [4:0]  flags;
    logic [5:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  rm;
    int          start;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [5:0]  m_op = '0;
  logic [31:0] m_rs1 = '0, m_rs2 = '0;
  logic [2:0]  m_rm = '0;
  logic [4:0]  acc_m = '0;
  bit          fresh = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) if (wb_rand) begin
    #1;
    bus.wb_ready = ($urandom % 4) != 0;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      fresh = 1'b1;
      acc_m = '0;
    end else begin
      check("fflags_acc", 64'(fflags_acc), 64'(acc_m));
      if (fflags_clr) acc_m = '0;
      if (flush) begin
        q.delete();
        fresh = 1'b1;
      end else begin
        if (q.size() > 0 && cyc >= q[0].start && cyc < q[0].due) begin
          check("issue_ready_low_in_exec", 64'(bus.issue_ready), 64'(0));
          check("wb_valid_early", 64'(bus.wb_valid), 64'(0));
        end
        if (q.size() > 0 && cyc == q[0].due && fresh)
          check("wb_valid_on_time", 64'(bus.wb_valid), 64'(1));
        if (bus.wb_valid) begin
          if (q.size() == 0) begin
            check("spurious_wb_valid", 64'(bus.wb_valid), 64'(0));
          end else begin
            if (fresh) begin
              check("wb_latency", 64'(cyc), 64'(q[0].due));
              check("fpu_op", 64'(fpu_op), 64'(q[0].op));
              check("fpu_rs1", 64'(fpu_rs1), 64'(q[0].rs1));
              check("fpu_rs2", 64'(fpu_rs2), 64'(q[0].rs2));
              check("fpu_rm", 64'(fpu_rm), 64'(q[0].rm));
              fresh = 1'b0;
            end
            check("wb_data", 64'(bus.wb_data), 64'(q[0].data));
            check("wb_rd", 64'(bus.wb_rd), 64'(q[0].rd));
            check("wb_flags", 64'(bus.wb_flags), 64'(q[0].flags));
            if (bus.wb_ready) begin
`ifdef FPU_SEQ_FLAGS_EN
              if (!fflags_clr) acc_m = acc_m | q[0].flags;
`endif
              void'(q.pop_front());
              fresh = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [2:0] rm);
    exp_t e;
    logic [2:0] rr;
    bit done;
    done = 1'b0;
    bus.issue_valid = 1'b1;
    bus.issue_op = op;
    bus.issue_rs1 = a;
    bus.issue_rs2 = b;
    bus.issue_rd = rd;
    bus.issue_rm = rm;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.issue_ready) begin
        rr = (rm == 3'd7) ? fcsr_frm : rm;
        e.rd = rd;
        e.start = cyc + 1;
        if (op >= 6'd8 || rr >= 3'd5) begin
          e.data = '0;
          e.flags = 5'b10000;
          e.due = cyc + 1;
        end else begin
          m_op = op; m_rs1 = a; m_rs2 = b; m_rm = rr;
          e.data = dp_res(op, a, b, rr);
          e.flags = a[4:0];
          e.due = cyc + 1 + lat_of(op);
        end
        e.op = m_op; e.rs1 = m_rs1; e.rs2 = m_rs2; e.rm = m_rm;
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.issue_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL issue_timeout: got no accept expected accept of op %0d", op);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.wb_valid;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL wait_valid_timeout: got wb_valid=0 expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_issue_ready"}, 64'(bus.issue_ready), 64'(1));
    check({p, "_wb_valid"}, 64'(bus.wb_valid), 64'(0));
    check({p, "_busy"}, 64'(busy), 64'(0));
    check({p, "_fpu_op"}, 64'(fpu_op), 64'(0));
    check({p, "_fpu_rs1"}, 64'(fpu_rs1), 64'(0));
    check({p, "_fpu_rs2"}, 64'(fpu_rs2), 64'(0));
    check({p, "_fpu_rm"}, 64'(fpu_rm), 64'(0));
    check({p, "_wb_data"}, 64'(bus.wb_data), 64'(0));
    check({p, "_wb_rd"}, 64'(bus.wb_rd), 64'(0));
    check({p, "_wb_flags"}, 64'(bus.wb_flags), 64'(0));
    check({p, "_fflags_acc"}, 64'(fflags_acc), 64'(0));
  endtask

  initial begin
    bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.issue_rd = '0; bus.issue_rm = '0; bus.wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check_reset_vals("reset");

    // fadd 1.0 + 2.0
    issue(6'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5, 3'd0);
    drain();

    // fdiv held in DONE for 10 cycles, then handshake with simultaneous fmul accept
    bus.wb_ready = 1'b0;
    issue(6'd2, 32'h4120_0000, 32'h4000_0000, 5'd7, 3'd1);
    wait_valid();
    repeat (10) @(posedge clk);
    #1 bus.wb_ready = 1'b1;
    issue(6'd1, 32'h4040_0000, 32'h4080_0000, 5'd9, 3'd2);
    drain();

    // Illegal op code and illegal static rounding mode
    issue(6'd9, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 3'd0);
    drain();
    issue(6'd0, 32'h1111_1111, 32'h2222_2222, 5'd4, 3'd5);
    drain();

    // Dynamic rounding mode
    fcsr_frm = 3'b010;
    issue(6'd1, 32'h3FC0_0000, 32'h4000_0000, 5'd11, 3'd7);
    drain();
    check("fpu_rm_dynamic", 64'(fpu_rm), 64'(3'b010));

    // Flush in the 5th EXEC cycle of fsqrt
    issue(6'd3, 32'h4110_0000, 32'h0, 5'd12, 3'd0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_wb_valid", 64'(bus.wb_valid), 64'(0));
    repeat (20) @(posedge clk);
    #1;

    // Reset mid-fdiv
    issue(6'd2, 32'h4000_0000, 32'h4040_0000, 5'd13, 3'd0);
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rm = '0;
    @(posedge clk);
    #1 check_reset_vals("midreset");
    resetn = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Sticky flag accumulation and clear priority
    fflags_clr = 1'b1;
    @(posedge clk);
    #1 fflags_clr = 1'b0;
    issue(6'd0, 32'h0000_0001, 32'h3F80_0000, 5'd1, 3'd0);
    drain();
    issue(6'd1, 32'h0000_0004, 32'h3F80_0000, 5'd2, 3'd0);
    drain();
`ifdef FPU_SEQ_FLAGS_EN
    check("acc_two_wb", 64'(fflags_acc), 64'(5'b00101));
`else
    check("acc_two_wb", 64'(fflags_acc), 64'(5'b00000));
`endif
    bus.wb_ready = 1'b0;
    issue(6'd9, 32'h0, 32'h0, 5'd6, 3'd0);
    wait_valid();
    bus.wb_ready = 1'b1;
    fflags_clr = 1'b1;
    @(posedge clk);
    #1 fflags_clr = 1'b0;
    check("acc_clr_wins", 64'(fflags_acc), 64'(0));
    drain();

    // Randomized traffic with random wb backpressure and occasional flushes
    wb_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      op = (($urandom % 10) < 8) ? 6'($urandom % 8) : 6'(8 + ($urandom % 56));
      fcsr_frm = 3'($urandom % 8);
      issue(op, $urandom, $urandom, 5'($urandom), 3'($urandom % 8));
      if (($urandom % 16) == 0) begin
        repeat ($urandom % 4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end else if (($urandom % 4) == 0) begin
        repeat ($urandom % 6) @(posedge clk);
        #1;
      end
    end
    wb_rand = 1'b0;
    @(posedge clk);
    #2 bus.wb_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fpu_seq.md
# fpu_seq

Sequencer for the shared single-precision FPU datapath. Accepts one FP operation at a time from the integer pipeline through a valid/ready issue port. Drives the datapath's operation and operand inputs and holds them stable for the operation's fixed latency. Captures the result and exception flags, then returns them through a valid/ready writeback port tagged with the destination register.

## Interface
- `LAT_ADD`, 3: cycles from operands-stable to result-valid for op 0 (fadd); minimum 1.
- `LAT_MUL`, 3: latency for op 1 (fmul).
- `LAT_DIV`, 16: latency for op 2 (fdiv).
- `LAT_SQRT`, 16: latency for op 3 (fsqrt).
- `LAT_CVT`, 2: latency for ops 4–7 (fcvt.s.w, fcvt.s.wu, fcvt.w.s, fcvt.wu.s).
- `clk` in 1: clock; all state updates on rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `issue_valid` in 1: request presents an operation.
- `issue_ready` out 1: block accepts the request this cycle.
- `issue_op` in 6: operation code 0–7; 8–63 illegal.
- `issue_rs1`, `issue_rs2` in 32: operands.
- `issue_rd` in 5: destination register tag.
- `issue_rm` in 3: rounding mode; 3'b111 selects `fcsr_frm`.
- `fcsr_frm` in 3: dynamic rounding mode from fcsr[7:5].
- `flush` in 1: abort the in-flight operation.
- `fpu_op` out 6: operation to datapath.
- `fpu_rs1`, `fpu_rs2` out 32: operands to datapath.
- `fpu_rm` out 3: resolved rounding mode.
- `fpu_result` in 32: datapath result.
- `fpu_flags` in 5: datapath flags {NV,DZ,OF,UF,NX}.
- `wb_valid` out 1: result available.
- `wb_ready` in 1: consumer takes the result.
- `wb_data` out 32: result.
- `wb_rd` out 5: destination tag.
- `wb_flags` out 5: flags of this operation.
- `busy` out 1: high in EXEC or DONE.
- `fflags_acc` out 5: sticky accumulated flags (see Configuration).
- `fflags_clr` in 1: clear `fflags_acc`.

## Operation
- FSM states: IDLE, EXEC, DONE.
- `issue_ready` = (state==IDLE) | (state==DONE & `wb_ready`). `flush` forces it low.
- Accept condition: `issue_valid & issue_ready`.
- On accept:
  - Register `issue_op`, `issue_rs1`, `issue_rs2` into `fpu_op`, `fpu_rs1`, `fpu_rs2`.
  - Register the resolved rounding mode into `fpu_rm`: `issue_rm`, or `fcsr_frm` when `issue_rm`==7.
  - Register `issue_rd`.
  - Load the down-counter `cnt` with the op's LAT parameter.
  - Go to EXEC.
- Illegal request: op ≥ 8, or resolved rm ∈ {5,6,7}.
  - No EXEC; go directly to DONE.
  - `wb_data`=0, `wb_flags`=5'b10000 (NV).
  - `fpu_*` outputs are not updated.
- EXEC:
  - `fpu_*` outputs held stable; `cnt` decrements each cycle.
  - In the cycle `cnt`==1, register `fpu_result` into `wb_data` and `fpu_flags` into `wb_flags`, then go to DONE.
- DONE:
  - `wb_valid`=1; `wb_data`, `wb_rd`, `wb_flags` held stable until `wb_ready`.
  - On `wb_ready`: go to IDLE, or reload EXEC (or DONE if illegal) when a new request is accepted in the same cycle.
- `flush` in any state: go to IDLE next cycle, no writeback.
  - `flush` overrides a simultaneous issue and a simultaneous wb handshake.
  - A wb handshake coinciding with `flush` does not count as a writeback for flag accumulation.
- Reset values: state IDLE; `issue_ready`=1 after reset; `cnt`=0.
  - `wb_valid`=0, `busy`=0.
  - `fpu_op`=0, `fpu_rs1`=`fpu_rs2`=0, `fpu_rm`=0.
  - `wb_data`=0, `wb_rd`=0, `wb_flags`=0, `fflags_acc`=0.
- Reset mid-operation: the operation is discarded and no `wb_valid` is produced.

## Timing
- Request accepted at edge of cycle N: `fpu_*` valid from N+1; state EXEC from N+1 with `cnt`=LAT.
- Result captured at end of cycle N+LAT; `wb_valid` high from cycle N+LAT+1.
- Issue-to-writeback = LAT+1 cycles.
- Illegal op: `wb_valid` in N+1.
- Back-to-back issue (DONE handshake plus new accept in the same cycle): throughput is one op per LAT+1 cycles, with no idle bubble.
- `wb_valid` has no combinational path from `issue_*`.
- `issue_ready` has a combinational path from `wb_ready` and `flush` only.

## Configuration
- `FPU_SEQ_FLAGS_EN` defined:
  - `fflags_acc` |= `wb_flags` on every cycle with `wb_valid & wb_ready & !flush`.
  - `fflags_clr` clears `fflags_acc`. When a clear and a set occur in the same cycle, the clear wins and the register becomes 0.
- `FPU_SEQ_FLAGS_EN` not defined:
  - `fflags_acc` is constant 0 and `fflags_clr` is ignored.
  - No accumulation register is synthesized; `wb_flags` is still produced.

## Test plan
- Reset, then fadd (op 0) with rs1=0x3F800000, rs2=0x40000000, rd=5; datapath model returns 0x40400000 → `wb_valid` exactly 4 cycles after accept, `wb_data`=0x40400000, `wb_rd`=5, `issue_ready`=0 throughout EXEC.
- fdiv (op 2) with `wb_ready` held low for 10 cycles after `wb_valid` → outputs stable; then `wb_ready`=1 with a simultaneous fmul issue → fmul accepted the same cycle, its `wb_valid` 4 cycles later.
- Op 9, and op 0 with rm=5 → `wb_valid` 1 cycle after accept, `wb_data`=0, `wb_flags`=5'b10000; `fpu_op` unchanged.
- `issue_rm`=7 with `fcsr_frm`=3'b010 → `fpu_rm`=3'b010.
- `flush` asserted in the 5th EXEC cycle of fsqrt → IDLE next cycle, no `wb_valid`; `resetn` low mid-fdiv → all outputs at their reset values next cycle.
- With `FPU_SEQ_FLAGS_EN`: two writebacks with flags 5'b00001 then 5'b00100 → `fflags_acc`=5'b00101; `fflags_clr` together with a writeback of 5'b10000 → `fflags_acc`=0. Without the macro → `fflags_acc`=0 throughout.
